// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller and its byte store.
package data_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int LAT_CNT_W = $clog2(4) + 1;

    // Inputs are zero-extended by the caller so the top byte address cannot wrap.
    function automatic logic range_err(input logic [63:0] last_byte,
                                       input logic [63:0] depth);
        return last_byte >= depth;
    endfunction

endpackage

// File: rtl/data_mem_bytes.sv
// Byte-array storage: big-endian word view with per-lane writes and a combinational word read.
module data_mem_bytes
    import data_mem_pkg::*;
#(
    parameter int BYTES_PER_WORD = 3,
    parameter int DEPTH_BYTES    = 1024,
    parameter int ADDR_W         = 24
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [BYTES_PER_WORD-1:0]   byte_en,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [8*BYTES_PER_WORD-1:0] wdata,
    output logic [8*BYTES_PER_WORD-1:0] rdata
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    logic [7:0]       mem [DEPTH_BYTES];
    logic [IDX_W-1:0] idx [BYTES_PER_WORD];

    // Lane g is the byte at addr + (BPW-1-g); the MSB lane sits at addr itself.
    for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
        assign idx[g] = IDX_W'(addr + ADDR_W'(BYTES_PER_WORD - 1 - g));
        assign rdata[8*g +: 8] = mem[idx[g]];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (byte_en[i]) begin
                    mem[idx[i]] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Request/response controller around the byte store with fixed read latency and error pulses.
// Define DATA_MEM_ALIGN_CHECK_EN to also flag addresses that are not a multiple of BYTES_PER_WORD.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int BYTES_PER_WORD = 3,
    parameter int DEPTH_BYTES    = 1024,
    parameter int ADDR_W         = 24,
    parameter int RD_LAT         = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    input  logic                        wr,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [8*BYTES_PER_WORD-1:0] wdata,
    input  logic [BYTES_PER_WORD-1:0]   byte_en,
    output logic                        ready,
    output logic [8*BYTES_PER_WORD-1:0] rdata,
    output logic                        rvalid,
    output logic                        done,
    output logic                        err
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = (RD_LAT > 1) ? LAT_CNT_W'(RD_LAT - 2) : '0;

    state_t               state;
    state_t               state_next;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 wr_p0;
    logic                 err_p0;
    logic [WORD_W-1:0]    hold_p0;
    logic [WORD_W-1:0]    mem_rdata;
    logic [ADDR_W:0]      last_byte;
    logic                 range_bad;
    logic                 align_bad;
    logic                 err_now;
    logic                 accept;

    assign accept    = ready && req;
    assign last_byte = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
    assign range_bad = range_err(64'(last_byte), 64'(DEPTH_BYTES));

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign align_bad = (addr % ADDR_W'(BYTES_PER_WORD)) != '0;
`else
    assign align_bad = 1'b0;
`endif

    assign err_now = range_bad | align_bad;

    data_mem_bytes #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .DEPTH_BYTES    (DEPTH_BYTES),
        .ADDR_W         (ADDR_W)
    ) u_bytes (
        .clk     (clk),
        .we      (accept && wr && !err_now),
        .byte_en (byte_en),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (wr || RD_LAT == 1) ? RESP : WAIT;
            WAIT: if (lat_cnt == '0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset keeps every strobe low for the whole reset window.
    always_comb begin
        ready  = reset && (state == IDLE);
        rvalid = reset && (state == RESP) && !wr_p0;
        done   = reset && (state == RESP) && wr_p0;
        err    = reset && (state == RESP) && err_p0;
    end

    // Acceptance stage: capture the access kind, its error and the latency count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt <= '0;
            wr_p0   <= 1'b0;
            err_p0  <= 1'b0;
        end else if (accept) begin
            lat_cnt <= LAT_LOAD;
            wr_p0   <= wr;
            err_p0  <= err_now;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !wr) begin
            hold_p0 <= err_now ? '0 : mem_rdata;
        end
    end

    // Response stage: rdata changes only when a read response is about to be presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (accept && !wr && RD_LAT == 1) begin
            rdata <= err_now ? '0 : mem_rdata;
        end else if (state == WAIT && lat_cnt == '0) begin
            rdata <= hold_p0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl with read latencies 1, 3 and 4 side by side.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    localparam int NI = 3;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        int          k;
        bit          w;
        logic [23:0] rd;
        bit          e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [2:0]  byte_en;
    logic        req_a    [NI];
    logic        ready_a  [NI];
    logic        rvalid_a [NI];
    logic        done_a   [NI];
    logic        err_a    [NI];
    logic [23:0] rdata_a  [NI];

    exp_t        sb [$];
    logic [7:0]  mdl [NI][1024];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req_a[0]), .wr(wr), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .ready(ready_a[0]), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]),
        .done(done_a[0]), .err(err_a[0]));

    data_mem_ctrl #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .req(req_a[1]), .wr(wr), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .ready(ready_a[1]), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]),
        .done(done_a[1]), .err(err_a[1]));

    data_mem_ctrl #(.RD_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset), .req(req_a[2]), .wr(wr), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .ready(ready_a[2]), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]),
        .done(done_a[2]), .err(err_a[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic bit exp_err(input logic [23:0] a);
        logic [24:0] last;
        last = {1'b0, a} + 25'd2;
        return (last >= 25'd1024) || (ALIGN && (a % 24'd3 != 24'd0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Response monitor: every rvalid/done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (rvalid_a[k] === 1'b1 || done_a[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(k), 32'd99);
                end else begin
                    e = sb.pop_front();
                    chk("resp_inst", 32'(k), 32'(e.k));
                    chk("resp_kind", 32'({done_a[k], rvalid_a[k]}), e.w ? 32'd2 : 32'd1);
                    if (!e.w) chk("rdata", 32'(rdata_a[k]), 32'(e.rd));
                    chk("err", 32'(err_a[k]), 32'(e.e));
                end
            end
        end
    end

    task automatic access(input int k, input bit w, input logic [23:0] a,
                          input logic [23:0] d, input logic [2:0] be);
        exp_t        e;
        int          n;
        int          ia;
        bit          got;
        logic [23:0] rd_exp;
        @(negedge clk);
        chk("ready_idle", 32'(ready_a[k]), 32'd1);
        ia     = int'(a);
        e.k    = k;
        e.w    = w;
        e.e    = exp_err(a);
        rd_exp = 24'h0;
        if (!w && !e.e) rd_exp = {mdl[k][ia], mdl[k][ia+1], mdl[k][ia+2]};
        e.rd = rd_exp;
        if (w && !e.e) begin
            for (int i = 0; i < 3; i++) begin
                if (be[i]) mdl[k][ia+2-i] = d[8*i +: 8];
            end
        end
        sb.push_back(e);
        req_a[k] = 1'b1;
        wr       = w;
        addr     = a;
        wdata    = d;
        byte_en  = be;
        @(posedge clk);
        #1;
        req_a[k] = 1'b0;
        wr       = 1'($urandom);
        addr     = 24'($urandom);
        wdata    = 24'($urandom);
        byte_en  = 3'($urandom);
        got      = 1'b0;
        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk("ready_busy", 32'(ready_a[k]), 32'd0);
            if (rvalid_a[k] || done_a[k]) begin
                got = 1'b1;
                break;
            end
        end
        chk("latency", got ? 32'(n) : 32'd0, w ? 32'd1 : 32'(lat_of(k)));
        @(negedge clk);
        chk("pulse_fall", 32'({rvalid_a[k], done_a[k], err_a[k]}), 32'd0);
        chk("ready_back", 32'(ready_a[k]), 32'd1);
        if (!w) chk("rdata_hold", 32'(rdata_a[k]), 32'(rd_exp));
    endtask

    initial begin
        reset   = 1'b0;
        wr      = 1'b0;
        addr    = 24'h0;
        wdata   = 24'h0;
        byte_en = 3'h0;
        for (int k = 0; k < NI; k++) req_a[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(ready_a[k]), 32'd0);
            chk("rst_strobes", 32'({rvalid_a[k], done_a[k], err_a[k]}), 32'd0);
            chk("rst_rdata", 32'(rdata_a[k]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk("ready_after_rst", 32'(ready_a[k]), 32'd1);

        // Preload aligned words around 0x10 so later reads never touch unwritten bytes.
        access(0, 1'b1, 24'h00000F, 24'h010203, 3'b111);
        access(0, 1'b1, 24'h000012, 24'h040506, 3'b111);

        access(0, 1'b1, 24'h000010, 24'hA1B2C3, 3'b111);
        access(0, 1'b0, 24'h000010, 24'h000000, 3'b000);

        access(0, 1'b1, 24'h000020, 24'h112233, 3'b111);
        access(0, 1'b1, 24'h000020, 24'hFFFFFF, 3'b010);
        access(0, 1'b0, 24'h000020, 24'h000000, 3'b000);
        access(0, 1'b1, 24'h000020, 24'h000000, 3'b000);
        access(0, 1'b0, 24'h000020, 24'h000000, 3'b000);

        access(0, 1'b1, 24'h0003FD, 24'h445566, 3'b111);
        access(0, 1'b0, 24'd1022,   24'h000000, 3'b000);
        access(0, 1'b1, 24'hFFFFFF, 24'hDEADBE, 3'b111);
        access(0, 1'b1, 24'h0003FE, 24'h778899, 3'b111);
        access(0, 1'b0, 24'h0003FD, 24'h000000, 3'b000);

        access(0, 1'b1, 24'h000011, 24'h778899, 3'b111);
        access(0, 1'b0, 24'h00000F, 24'h000000, 3'b000);
        access(0, 1'b0, 24'h000012, 24'h000000, 3'b000);

        access(1, 1'b1, 24'h000030, 24'hCAFE01, 3'b111);
        access(1, 1'b0, 24'h000030, 24'h000000, 3'b000);
        access(1, 1'b0, 24'd1022,   24'h000000, 3'b000);

        // Reset lands two cycles into a latency-4 read; that response must never appear.
        access(2, 1'b1, 24'h000030, 24'h5A6B7C, 3'b111);
        @(negedge clk);
        req_a[2] = 1'b1;
        wr       = 1'b0;
        addr     = 24'h000030;
        @(posedge clk);
        #1;
        req_a[2] = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(ready_a[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_ready", 32'(ready_a[2]), 32'd0);
            chk("mid_rst_rdata", 32'(rdata_a[2]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(ready_a[2]), 32'd1);
        repeat (6) @(negedge clk);
        access(2, 1'b0, 24'h000030, 24'h000000, 3'b000);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
